// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and constants
// for the iterative multiply/divide sequencer.
package mdu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN_DEF-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration on the {hi,lo} register pair.
// Multiply is shift-add (right); divide is restoring shift-subtract (left).
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_sh;
    logic [XLEN:0] w_diff;

    // Remainder stays below the divisor, so the diff's top bit is a borrow
    always_comb begin
        w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        w_sh   = {i_hi, i_lo[XLEN-1]};
        w_diff = w_sh - {1'b0, i_opnd};
        if (i_div) begin
            if (!w_diff[XLEN]) begin
                o_hi = w_diff[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b1};
            end else begin
                o_hi = w_sh[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[XLEN:1];
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer, XLEN+1 cycle latency.
// Optional MDU_FAST_PATH_EN: zero/div-by-zero/overflow finish in one cycle.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] md_result
);

    mdu_state_e       r_state;
    mdu_state_e       w_state_n;
    mdu_op_e          r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opnd;
    logic [XLEN-1:0]  r_result;
    logic             r_neg;
    logic             r_dz;

    mdu_op_e           w_op;
    logic              w_acc;
    logic              w_is_div;
    logic              w_s1;
    logic              w_s2;
    logic              w_neg;
    logic              w_dz;
    logic              w_mz;
    logic              w_fast;
    logic [XLEN-1:0]   w_m1;
    logic [XLEN-1:0]   w_m2;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign md_result = r_result;

    assign w_acc = in_ready && in_valid && !flush;

    mdu_step #(.XLEN(XLEN)) u_step (
        .i_div  (r_op[2]),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_hi_n),
        .o_lo   (w_lo_n)
    );

    // Request decode: operand signs, magnitudes and special cases
    always_comb begin
        w_op     = mdu_op_e'(op);
        w_is_div = op[2];
        w_s1 = num1[XLEN-1] &&
               (w_op inside {MDU_MUL, MDU_MULH, MDU_MULHSU,
                             MDU_DIV, MDU_REM});
        w_s2 = num2[XLEN-1] &&
               (w_op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM});
        w_m1  = w_s1 ? -num1 : num1;
        w_m2  = w_s2 ? -num2 : num2;
        w_neg = (w_op == MDU_REM) ? w_s1 : (w_s1 ^ w_s2);
        w_dz  = w_is_div && (num2 == '0);
        w_mz  = !w_is_div && ((num1 == '0) || (num2 == '0));
        if (w_mz)
            w_fast_res = '0;
        else if (w_dz)
            w_fast_res = op[1] ? num1 : {XLEN{1'b1}};
        else
            w_fast_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MDU_FAST_PATH_EN
    logic w_ovf;
    assign w_ovf = w_is_div && !op[0] &&
                   (num1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (num2 == {XLEN{1'b1}});
    assign w_fast = w_mz || w_dz || w_ovf;
`else
    assign w_fast = 1'b0;
`endif

    // Final signed result from the last step's outputs
    always_comb begin
        w_prod_s = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
        w_quo    = r_neg ? -w_lo_n : w_lo_n;
        w_rem    = r_neg ? -w_hi_n : w_hi_n;
        w_final  = '0;
        unique case (r_op)
            MDU_MUL:
                w_final = w_prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:
                w_final = w_prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:
                w_final = r_dz ? {XLEN{1'b1}} : w_quo;
            MDU_REM, MDU_REMU:
                w_final = w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    // Next state; flush beats both accept and out_ready
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_acc) w_state_n = w_fast ? ST_DONE : ST_BUSY;
            ST_BUSY:
                if (flush)
                    w_state_n = ST_IDLE;
                else if (r_cnt == CNT_W'(1))
                    w_state_n = ST_DONE;
            ST_DONE:
                if (flush || out_ready) w_state_n = ST_IDLE;
            default:
                w_state_n = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= MDU_MUL;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_acc) begin
            r_op   <= w_op;
            r_neg  <= w_neg;
            r_dz   <= w_dz;
            r_cnt  <= CNT_W'(XLEN);
            r_hi   <= '0;
            r_lo   <= w_is_div ? w_m1 : w_m2;
            r_opnd <= w_is_div ? w_m2 : w_m1;
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == ST_BUSY) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_result <= w_final;
        end
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the NPC execute stage.
- Removes the combinational `*` and `/` from the single-cycle ALU path.
- Runs RV32M ops over multiple cycles: shift-add multiply, restoring divide.
- Uses a valid/ready handshake; the EXU stalls while the result is pending.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- num1  in  XLEN  rs1 value (multiplicand / dividend).
- num2  in  XLEN  rs2 value (multiplier / divisor).
- flush  in  1  abort the in-flight op.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- md_result  out  XLEN  result.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. During rst: state=IDLE, in_ready=1, out_valid=0, md_result=0, counter=0, all working regs=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid (handshake), latch op, take operand magnitudes (sign per op), record result sign, set cnt=XLEN, go to BUSY. Fast path (see Optional Feature) goes straight to DONE.
  - BUSY: in_ready=0, out_valid=0. One radix-2 step per cycle; cnt decrements. When cnt reaches 1 and the step completes, form the final signed result and go to DONE.
  - DONE: out_valid=1, md_result stable. On out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no back-to-back accept in the same cycle.
- Latency: accept edge at cycle N gives out_valid=1 from cycle N+XLEN+1 (33 for XLEN=32). Result is held until out_ready.
- Multiply: 2*XLEN-bit product.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - Signedness is per RV32M: MULHSU treats num1 signed, num2 unsigned.
  - Negative results use two's complement of the 64-bit magnitude product.
- Divide:
  - Quotient sign = sign1^sign2 (signed ops).
  - Remainder sign = dividend sign.
- Divide by zero (num2==0): DIV/DIVU give all-ones; REM/REMU give num1.
- Signed overflow (num1=0x80000000, num2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Special cases take full latency unless the fast path is enabled.
- flush:
  - In BUSY or DONE: next cycle is IDLE, out_valid=0, result discarded.
  - In IDLE: same-cycle in_valid is ignored (flush wins).
- Simultaneous out_ready and flush in DONE: flush wins. The consumer must not commit.
- Reset mid-operation: state returns to IDLE immediately (async); no out_valid pulse.
- Inputs are only sampled at accept. num1/num2/op changes during BUSY have no effect.

Optional Feature:
- Macro: MDU_FAST_PATH_EN.
- Defined:
  - Divide-by-zero, signed overflow, and multiply with either operand zero go IDLE→DONE directly.
  - out_valid at N+1; md_result per the special-case rules above.
- Undefined:
  - All ops use the fixed XLEN+1-cycle latency.
  - Results are identical either way.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MDU_MUL..MDU_REMU, 3-bit.
  - state enum: ST_IDLE, ST_BUSY, ST_DONE.
  - constants: XLEN_DEF=32, DIV0_QUOT=all-ones, INT_MIN=0x80000000.
- One sub-module: mdu_step, combinational.
  - Inputs: current accumulator/remainder, operand, mode bit.
  - Output: next shift-add or shift-subtract state.
  - Keeps the FSM in mdu_seq.

Test Plan:
- MUL: 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFE; out_valid at N+33. MULHU on the same operands → 0x00000001.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHSU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV: 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3).
  - REM: same operands → 0xFFFFFFFF (-1).
  - DIVU: 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Corner cases:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - With MDU_FAST_PATH_EN these complete at N+1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid and md_result stable, in_ready=0.
  - out_ready=1 → IDLE next cycle.
- flush asserted in BUSY at cycle N+10 → IDLE at N+11, no out_valid. Then rst asserted mid-BUSY → outputs at reset values immediately.
